// File: rtl/gpr_scoreboard.sv
// Issue-side hazard scoreboard for the R/F/M register groups: one busy bit per
// register, RAW/WAW/in-flight-limit issue blocking, and clearing on writeback.
module gpr_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [1:0]       rs1_group,
  input  logic [4:0]       rs1_index,
  input  logic [1:0]       rs2_group,
  input  logic [4:0]       rs2_index,
  input  logic [1:0]       rs3_group,
  input  logic [4:0]       rs3_index,
  input  logic [1:0]       rd_group,
  input  logic [4:0]       rd_index,
  output logic             ex_valid,
  input  logic             ex_ready,
  input  logic             wb_valid,
  input  logic [1:0]       wb_group,
  input  logic [4:0]       wb_index,
  output logic [CNT_W-1:0] inflight,
  output logic [31:0]      stall_cycles,
  output logic             err
);
  localparam logic [1:0] REG_GROUP_R = 2'd0;
  localparam logic [1:0] REG_GROUP_F = 2'd1;
  localparam logic [1:0] REG_GROUP_M = 2'd2;

  logic [31:0] busy_r, busy_f, busy_m;
  logic [31:0] busy_r_n, busy_f_n, busy_m_n;
  logic        hazard, full, fire, rd_write, wb_write, wb_hit, do_inc, do_dec;

  function automatic logic busy_bit(input logic [1:0] g, input logic [4:0] i,
                                    input logic [31:0] br, input logic [31:0] bf,
                                    input logic [31:0] bm);
    case (g)
      REG_GROUP_R: busy_bit = br[i];
      REG_GROUP_F: busy_bit = bf[i];
      REG_GROUP_M: busy_bit = bm[i];
      default:     busy_bit = 1'b0;
    endcase
  endfunction

  // A write to R0 is discarded, so it neither sets busy nor counts in flight.
  function automatic logic is_write(input logic [1:0] g, input logic [4:0] i);
    is_write = (g == REG_GROUP_R && i != 5'd0) || g == REG_GROUP_F || g == REG_GROUP_M;
  endfunction

  // Handshake: ex_valid and id_ready are each gated only by registered hazard
  // state; an instruction transfers (fire) when id_valid & id_ready.
  always_comb begin
    rd_write = is_write(rd_group, rd_index);
    hazard   = busy_bit(rs1_group, rs1_index, busy_r, busy_f, busy_m)
             | busy_bit(rs2_group, rs2_index, busy_r, busy_f, busy_m)
             | busy_bit(rs3_group, rs3_index, busy_r, busy_f, busy_m)
             | (rd_write & busy_bit(rd_group, rd_index, busy_r, busy_f, busy_m));
    full     = (inflight == CNT_W'(MAX_INFLIGHT)) & rd_write;
    ex_valid = id_valid & ~hazard & ~full;
    id_ready = ex_ready & ~hazard & ~full;
    fire     = id_valid & id_ready;
    wb_write = wb_valid & is_write(wb_group, wb_index);
    wb_hit   = wb_write & busy_bit(wb_group, wb_index, busy_r, busy_f, busy_m)
             & (inflight != '0);
    do_inc   = fire & rd_write;
    do_dec   = wb_hit;
  end

  // Clear first, then set, so an issue to the same register wins.
  always_comb begin
    busy_r_n = busy_r;
    busy_f_n = busy_f;
    busy_m_n = busy_m;
    if (wb_hit) begin
      case (wb_group)
        REG_GROUP_R: busy_r_n[wb_index] = 1'b0;
        REG_GROUP_F: busy_f_n[wb_index] = 1'b0;
        REG_GROUP_M: busy_m_n[wb_index] = 1'b0;
        default: ;
      endcase
    end
    if (do_inc) begin
      case (rd_group)
        REG_GROUP_R: busy_r_n[rd_index] = 1'b1;
        REG_GROUP_F: busy_f_n[rd_index] = 1'b1;
        REG_GROUP_M: busy_m_n[rd_index] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r       <= '0;
      busy_f       <= '0;
      busy_m       <= '0;
      inflight     <= '0;
      stall_cycles <= '0;
      err          <= 1'b0;
    end else begin
      busy_r <= busy_r_n;
      busy_f <= busy_f_n;
      busy_m <= busy_m_n;
      if (do_inc && !do_dec)      inflight <= inflight + CNT_W'(1);
      else if (!do_inc && do_dec) inflight <= inflight - CNT_W'(1);
      if (id_valid && !id_ready)  stall_cycles <= stall_cycles + 32'd1;
      if (wb_write && !wb_hit)    err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed bench for gpr_scoreboard: RAW/WAW stalls, in-flight limit, retire
// interactions, error flag and asynchronous reset.
module tb_gpr_scoreboard;
  localparam logic [1:0] GR = 2'd0, GF = 2'd1, GM = 2'd2, GN = 2'd3;

  logic        clk, rst;
  logic        id_valid, id_ready, ex_valid, ex_ready;
  logic [1:0]  rs1_group, rs2_group, rs3_group, rd_group, wb_group;
  logic [4:0]  rs1_index, rs2_index, rs3_index, rd_index, wb_index;
  logic        wb_valid, err;
  logic [3:0]  inflight;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  gpr_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .rs1_group(rs1_group), .rs1_index(rs1_index),
    .rs2_group(rs2_group), .rs2_index(rs2_index),
    .rs3_group(rs3_group), .rs3_index(rs3_index),
    .rd_group(rd_group), .rd_index(rd_index),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .wb_valid(wb_valid), .wb_group(wb_group), .wb_index(wb_index),
    .inflight(inflight), .stall_cycles(stall_cycles), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [1:0] s1g, input logic [4:0] s1i,
                       input logic [1:0] s2g, input logic [4:0] s2i,
                       input logic [1:0] dg,  input logic [4:0] di);
    id_valid  = 1'b1;
    rs1_group = s1g; rs1_index = s1i;
    rs2_group = s2g; rs2_index = s2i;
    rs3_group = GN;  rs3_index = 5'd0;
    rd_group  = dg;  rd_index  = di;
  endtask

  task automatic retire(input logic v, input logic [1:0] g, input logic [4:0] i);
    wb_valid = v; wb_group = g; wb_index = i;
  endtask

  initial begin
    rst = 1'b1; ex_ready = 1'b1; id_valid = 1'b0;
    rs1_group = GN; rs2_group = GN; rs3_group = GN; rd_group = GN;
    rs1_index = '0; rs2_index = '0; rs3_index = '0; rd_index = '0;
    retire(1'b0, GN, 5'd0);
    #12 rst = 1'b0;
    tick();
    chk("rst_inflight", inflight, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_err", err, 0);
    chk("rst_busy_r", dut.busy_r, 0);
    chk("rst_id_ready", id_ready, 1);
    chk("rst_ex_valid", ex_valid, 0);

    // Simple issue: rs1=R3, rd=R5
    instr(GR, 5'd3, GN, 5'd0, GR, 5'd5);
    #1;
    chk("t1_id_ready", id_ready, 1);
    chk("t1_ex_valid", ex_valid, 1);
    tick();
    chk("t1_busy_r5", dut.busy_r[5], 1);
    chk("t1_inflight", inflight, 1);

    // RAW on R5: stall, then retire R5, issue one cycle later
    instr(GN, 5'd0, GR, 5'd5, GR, 5'd6);
    #1;
    chk("raw_id_ready", id_ready, 0);
    chk("raw_ex_valid", ex_valid, 0);
    tick();
    chk("raw_stall1", stall_cycles, 1);
    tick();
    chk("raw_stall2", stall_cycles, 2);
    retire(1'b1, GR, 5'd5);
    #1;
    chk("raw_no_bypass", id_ready, 0);
    tick();
    retire(1'b0, GN, 5'd0);
    chk("raw_busy_r5_clr", dut.busy_r[5], 0);
    chk("raw_inflight0", inflight, 0);
    chk("raw_stall3", stall_cycles, 3);
    chk("raw_id_ready_now", id_ready, 1);
    tick();
    id_valid = 1'b0;
    chk("raw_busy_r6", dut.busy_r[6], 1);
    chk("raw_inflight1", inflight, 1);
    chk("raw_stall_hold", stall_cycles, 3);
    retire(1'b1, GR, 5'd6);
    tick();
    retire(1'b0, GN, 5'd0);
    chk("r6_retired", inflight, 0);

    // Writes to R0 are not writes
    instr(GN, 5'd0, GN, 5'd0, GR, 5'd0);
    for (int k = 0; k < 3; k++) tick();
    id_valid = 1'b0;
    chk("r0_inflight", inflight, 0);
    chk("r0_busy_r", dut.busy_r, 0);
    retire(1'b1, GR, 5'd0);
    tick();
    retire(1'b0, GN, 5'd0);
    chk("r0_wb_err", err, 0);
    chk("r0_wb_inflight", inflight, 0);

    // Fill to the in-flight limit
    instr(GN, 5'd0, GN, 5'd0, GF, 5'd1); tick();
    instr(GN, 5'd0, GN, 5'd0, GF, 5'd2); tick();
    instr(GN, 5'd0, GN, 5'd0, GM, 5'd0); tick();
    instr(GN, 5'd0, GN, 5'd0, GR, 5'd7); tick();
    chk("full_inflight4", inflight, 4);
    chk("full_busy_f", dut.busy_f, 32'h0000_0006);
    chk("full_busy_m", dut.busy_m, 32'h0000_0001);
    instr(GN, 5'd0, GN, 5'd0, GR, 5'd8);
    #1;
    chk("full_r8_stall", id_ready, 0);
    tick();
    instr(GR, 5'd1, GN, 5'd0, GN, 5'd0);
    #1;
    chk("full_nowrite_ready", id_ready, 1);
    chk("full_nowrite_valid", ex_valid, 1);
    tick();
    chk("full_nowrite_infl", inflight, 4);
    instr(GN, 5'd0, GN, 5'd0, GR, 5'd8);
    retire(1'b1, GF, 5'd1);
    #1;
    chk("full_r8_same_retire", id_ready, 0);
    tick();
    retire(1'b0, GN, 5'd0);
    chk("full_after_f1", inflight, 3);
    chk("full_f1_clr", dut.busy_f[1], 0);
    chk("full_r8_ready", id_ready, 1);
    tick();
    id_valid = 1'b0;
    chk("full_r8_infl", inflight, 4);
    chk("full_r8_busy", dut.busy_r[8], 1);

    // Retire R7, then same-cycle fire R9 and retire M0
    retire(1'b1, GR, 5'd7);
    tick();
    chk("r7_retired", inflight, 3);
    instr(GN, 5'd0, GN, 5'd0, GR, 5'd9);
    retire(1'b1, GM, 5'd0);
    #1;
    chk("both_id_ready", id_ready, 1);
    tick();
    id_valid = 1'b0;
    retire(1'b0, GN, 5'd0);
    chk("both_inflight", inflight, 3);
    chk("both_busy_r9", dut.busy_r[9], 1);
    chk("both_busy_m0", dut.busy_m[0], 0);

    // WAW on R9 blocks issue
    instr(GN, 5'd0, GN, 5'd0, GR, 5'd9);
    #1;
    chk("waw_id_ready", id_ready, 0);
    id_valid = 1'b0;

    // Spurious retire of F10
    retire(1'b1, GF, 5'd10);
    tick();
    retire(1'b0, GN, 5'd0);
    chk("spur_err", err, 1);
    chk("spur_inflight", inflight, 3);
    tick();
    chk("err_sticky", err, 1);

    // EX back-pressure: ex_valid independent of ex_ready, id_ready follows it
    ex_ready = 1'b0;
    instr(GR, 5'd2, GN, 5'd0, GN, 5'd0);
    #1;
    chk("bp_ex_valid", ex_valid, 1);
    chk("bp_id_ready", id_ready, 0);
    id_valid = 1'b0;
    ex_ready = 1'b1;

    // Asynchronous reset mid-cycle, no clock edge in between
    #2;
    rst = 1'b1;
    #1;
    chk("arst_err", err, 0);
    chk("arst_inflight", inflight, 0);
    chk("arst_stall", stall_cycles, 0);
    chk("arst_busy", dut.busy_r | dut.busy_f | dut.busy_m, 0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
